// File: rtl/cam_init_pkg.sv
// Shared types and constants for the OV7670 power-up init sequencer.
// Holds the FSM encoding, soft-reset register identity and delay counter width.
package cam_init_pkg;

    localparam int DLY_W = 20;

    localparam logic [7:0] SRST_REG = 8'h12;
    localparam int         SRST_BIT = 7;

    typedef logic [2:0] state_t;

    localparam state_t S_PWR     = 3'd0;
    localparam state_t S_FETCH   = 3'd1;
    localparam state_t S_ROMWAIT = 3'd2;
    localparam state_t S_REQ     = 3'd3;
    localparam state_t S_WAIT    = 3'd4;
    localparam state_t S_GAP     = 3'd5;
    localparam state_t S_DONE    = 3'd6;
    localparam state_t S_ERR     = 3'd7;

    // COM7 with bit 7 set resets the sensor, which then needs a long settle time.
    function automatic logic is_soft_reset(input logic [7:0] reg_addr, input logic [7:0] reg_data);
        return (reg_addr == SRST_REG) && reg_data[SRST_BIT];
    endfunction

endpackage

// File: rtl/cam_delay_cnt.sv
// Loadable down-counter shared by the power-up, inter-write and soft-reset waits.
// Counts toward zero and parks there; a load takes priority over counting.
module cam_delay_cnt
    import cam_init_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DLY_W-1:0] value,
    output logic             zero
);

    logic [DLY_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cam_init_seq.sv
// Walks the OV7670 init ROM after power-up and issues one SCCB write per entry,
// retrying NACKed writes and flagging completion or failure to the capture path.
module cam_init_seq
    import cam_init_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          TABLE_LEN  = 115,
    parameter logic [19:0] PWR_DELAY  = 20'd1000000,
    parameter logic [15:0] GAP_DELAY  = 16'd500,
    parameter logic [19:0] SRST_DELAY = 20'd50000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [15:0]           rom_q,
    input  logic                  wr_ready,
    output logic                  wr_req,
    output logic [7:0]            wr_reg,
    output logic [7:0]            wr_data,
    input  logic                  wr_done,
    input  logic                  wr_nack,
    output logic                  init_done,
    output logic                  init_err,
    output logic [ADDR_WIDTH-1:0] err_index
);

    localparam int                    RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(TABLE_LEN - 1);

    state_t             state;
    logic [RETRY_W-1:0] retry;
    logic               last_ack;
    logic               pwr_armed;
    logic               cnt_load;
    logic [DLY_W-1:0]   cnt_value;
    logic               cnt_zero;

    cam_delay_cnt u_delay (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .zero  (cnt_zero)
    );

    // The power wait spends one cycle arming, so the counter is loaded one short
    // to keep the total at PWR_DELAY+1 cycles, matching the gap waits.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = DLY_W'(GAP_DELAY);
        case (state)
            S_PWR: begin
                if (!pwr_armed && (PWR_DELAY != '0)) begin
                    cnt_load  = 1'b1;
                    cnt_value = PWR_DELAY - 20'd1;
                end
            end
            S_WAIT: begin
                if (wr_done) begin
                    cnt_load = 1'b1;
                    if (!wr_nack && is_soft_reset(wr_reg, wr_data)) begin
                        cnt_value = SRST_DELAY;
                    end
                end
            end
            default: ;
        endcase
    end

    assign wr_req = (state == S_REQ) && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_PWR;
            rom_addr  <= '0;
            wr_reg    <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            err_index <= '0;
            retry     <= '0;
            last_ack  <= 1'b0;
            pwr_armed <= 1'b0;
        end else begin
            case (state)
                S_PWR: begin
                    if (!pwr_armed) begin
                        if (PWR_DELAY == '0) state <= S_FETCH;
                        else                 pwr_armed <= 1'b1;
                    end else if (cnt_zero) begin
                        pwr_armed <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_ROMWAIT;
                S_ROMWAIT: begin
                    wr_reg  <= rom_q[15:8];
                    wr_data <= rom_q[7:0];
                    state   <= S_REQ;
                end
                S_REQ: begin
                    if (wr_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (wr_done) begin
                        if (!wr_nack) begin
                            retry    <= '0;
                            last_ack <= 1'b1;
                            state    <= S_GAP;
                        end else if (retry < RETRY_MAX) begin
                            retry    <= retry + 1'b1;
                            last_ack <= 1'b0;
                            state    <= S_GAP;
                        end else begin
                            err_index <= rom_addr;
                            init_err  <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_zero) begin
                        if (last_ack && (rom_addr == LAST_IDX)) begin
                            init_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            if (last_ack) rom_addr <= rom_addr + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        init_done <= 1'b0;
                        init_err  <= 1'b0;
                        rom_addr  <= '0;
                        retry     <= '0;
                        state     <= S_PWR;
                    end
                end
                default: state <= S_PWR;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// Self-checking bench for cam_init_seq: models the init ROM and an SCCB master
// with a scripted NACK plan, and compares request streams against a small model.
module tb_cam_init_seq;

    localparam int AW   = 8;
    localparam int MAXR = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          restart = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_q;
    logic          wr_ready;
    logic          wr_req;
    logic [7:0]    wr_reg;
    logic [7:0]    wr_data;
    logic          wr_done = 1'b0;
    logic          wr_nack = 1'b0;
    logic          init_done;
    logic          init_err;
    logic [AW-1:0] err_index;

    always #5 clk = ~clk;

    cam_init_seq #(
        .ADDR_WIDTH (AW),
        .TABLE_LEN  (3),
        .PWR_DELAY  (20'd10),
        .GAP_DELAY  (16'd4),
        .SRST_DELAY (20'd100),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .restart   (restart),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .wr_ready  (wr_ready),
        .wr_req    (wr_req),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .init_done (init_done),
        .init_err  (init_err),
        .err_index (err_index)
    );

    // Registered init ROM: data valid one cycle after the address is sampled.
    logic [15:0] rom [0:3];
    always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SCCB master model state and request log.
    logic        ready_en = 1'b1;
    logic        busy = 1'b0;
    logic        pending = 1'b0;
    int          wait_cnt = 0;
    logic [7:0]  cur_reg = 8'h00;
    int          nack_left [256];
    logic [15:0] req_q [$];
    int          req_cyc [$];
    int          done_cyc [$];
    logic        watch_stable = 1'b0;
    int          unstable = 0;

    assign wr_ready = ready_en && !busy;

    int total = 0;
    int bad = 0;
    int rel = 0;

    // wr_done lands 20 cycles after the request; the master ignores reset.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_done) begin
                wr_done = 1'b0;
                wr_nack = 1'b0;
            end
            if (busy) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    busy    = 1'b0;
                    wr_done = 1'b1;
                    wr_nack = (nack_left[cur_reg] > 0);
                    if (wr_nack) nack_left[cur_reg]--;
                    done_cyc.push_back(cyc);
                end
            end
            if (pending) begin
                pending  = 1'b0;
                busy     = 1'b1;
                wait_cnt = 19;
            end
            #1;
            if (watch_stable && done_cyc.size() == 1 && req_q.size() == 1 && wr_req !== 1'b1 &&
                (wr_reg !== 8'h12 || wr_data !== 8'h80))
                unstable++;
            if (wr_req === 1'b1) begin
                req_q.push_back({wr_reg, wr_data});
                req_cyc.push_back(cyc);
                cur_reg = wr_reg;
                pending = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        req_q.delete();
        req_cyc.delete();
        done_cyc.delete();
        unstable = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        rel = cyc + 1;
    endtask

    task automatic wait_end(input string name, input int budget);
        int k = 0;
        while (!(init_done === 1'b1 || init_err === 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, "_end_reached"}, 32'(k < budget), 32'd1);
    endtask

    function automatic int qcyc(input int which, input int k);
        if (which == 0) return (req_cyc.size() > k) ? req_cyc[k] : -1000;
        return (done_cyc.size() > k) ? done_cyc[k] : -1000;
    endfunction

    task automatic check_words(input string name, input logic [15:0] exp_q [$]);
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s_req%0d", name, k),
                  32'((req_q.size() > k) ? req_q[k] : 16'hxxxx), 32'(exp_q[k]));
        end
    endtask

    typedef struct {
        logic [15:0] rom0;
        int          nack1;
        int          nack2;
        int          exp_reqs;
        logic        exp_done;
        logic        exp_err;
        logic [7:0]  exp_eidx;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [15:0] exp_q [$];
        int          nk [3];
        int          att;

        for (int i = 0; i < 256; i++) nack_left[i] = 0;
        rom[0] = 16'h3a04; rom[1] = 16'h40d0; rom[2] = 16'h1204; rom[3] = 16'h0000;

        vecs[0] = '{16'h3a04, 0, 0, 3, 1'b1, 1'b0, 8'd0, 8'd2};
        vecs[1] = '{16'h1280, 0, 0, 3, 1'b1, 1'b0, 8'd0, 8'd2};
        vecs[2] = '{16'h3a04, 2, 0, 5, 1'b1, 1'b0, 8'd0, 8'd2};
        vecs[3] = '{16'h3a04, 0, 4, 6, 1'b0, 1'b1, 8'd2, 8'd2};
        vecs[4] = '{16'h3a04, 4, 0, 5, 1'b0, 1'b1, 8'd1, 8'd1};
        vecs[5] = '{16'h3a04, 3, 0, 6, 1'b1, 1'b0, 8'd0, 8'd2};

        // Reset values.
        do_reset(3);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_init_err", 32'(init_err), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);

        for (int i = 0; i < 6; i++) begin
            rom[0] = vecs[i].rom0; rom[1] = 16'h40d0; rom[2] = 16'h1204;
            for (int r = 0; r < 256; r++) nack_left[r] = 0;
            nack_left[8'h40] = vecs[i].nack1;
            nack_left[8'h12] = vecs[i].nack2;
            nk[0] = 0; nk[1] = vecs[i].nack1; nk[2] = vecs[i].nack2;
            exp_q.delete();
            for (int e = 0; e < 3; e++) begin
                att = (nk[e] > MAXR) ? MAXR + 1 : nk[e] + 1;
                repeat (att) exp_q.push_back(rom[e]);
                if (nk[e] > MAXR) break;
            end
            ready_en = 1'b1;
            watch_stable = (i == 1);
            clear_log();
            do_reset(3);
            wait_end($sformatf("v%0d", i), 3000);
            repeat (60) @(negedge clk);
            check($sformatf("v%0d_req_count", i), 32'(req_q.size()), 32'(vecs[i].exp_reqs));
            check_words($sformatf("v%0d", i), exp_q);
            check($sformatf("v%0d_init_done", i), 32'(init_done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_init_err", i), 32'(init_err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_err_index", i), 32'(err_index), 32'(vecs[i].exp_eidx));
            check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            check($sformatf("v%0d_first_req_lat", i), 32'(qcyc(0, 0) - rel), 32'd12);
            if (i == 0) check("v0_gap_lat", 32'(qcyc(0, 1) - qcyc(1, 0)), 32'd8);
            if (i == 1) begin
                check("v1_srst_lat", 32'(qcyc(0, 1) - qcyc(1, 0)), 32'd104);
                check("v1_srst_stable", 32'(unstable), 32'd0);
            end
            if (i == 2) check("v2_retry_gap_lat", 32'(qcyc(0, 2) - qcyc(1, 1)), 32'd8);
        end
        watch_stable = 1'b0;
        rom[0] = 16'h3a04;
        for (int r = 0; r < 256; r++) nack_left[r] = 0;
        exp_q.delete();
        exp_q.push_back(16'h3a04); exp_q.push_back(16'h40d0); exp_q.push_back(16'h1204);

        // wr_ready held low in S_REQ, then a restart pulse inside S_WAIT.
        ready_en = 1'b0;
        clear_log();
        do_reset(3);
        while (cyc < rel + 62) begin
            @(posedge clk);
            #1;
        end
        check("hold_no_req", 32'(req_q.size()), 32'd0);
        ready_en = 1'b1;
        for (int k = 0; k < 20 && req_q.size() == 0; k++) @(negedge clk);
        check("hold_req_lat", 32'(qcyc(0, 0) - rel), 32'd62);
        while (cyc < rel + 70) begin
            @(posedge clk);
            #1;
        end
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        wait_end("hold", 3000);
        repeat (40) @(negedge clk);
        check("hold_req_count", 32'(req_q.size()), 32'd3);
        check_words("hold", exp_q);
        check("hold_init_done", 32'(init_done), 32'd1);

        // Reset during S_WAIT of entry 1; the late wr_done falls in S_PWR.
        clear_log();
        do_reset(3);
        for (int k = 0; k < 300 && req_q.size() < 2; k++) @(negedge clk);
        while (cyc < rel + 48) begin
            @(posedge clk);
            #1;
        end
        do_reset(5);
        wait_end("midrst", 3000);
        repeat (40) @(negedge clk);
        check("midrst_req_count", 32'(req_q.size()), 32'd5);
        exp_q.push_front(16'h40d0);
        exp_q.push_front(16'h3a04);
        check_words("midrst", exp_q);
        check("midrst_relat", 32'(qcyc(0, 2) - rel), 32'd12);
        check("midrst_init_done", 32'(init_done), 32'd1);
        check("midrst_rom_addr", 32'(rom_addr), 32'd2);

        // Restart from S_DONE reruns the whole table.
        exp_q.delete();
        exp_q.push_back(16'h3a04); exp_q.push_back(16'h40d0); exp_q.push_back(16'h1204);
        clear_log();
        @(posedge clk);
        #1 restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        rel = cyc + 1;
        @(negedge clk);
        check("restart_clears_done", 32'(init_done), 32'd0);
        check("restart_clears_addr", 32'(rom_addr), 32'd0);
        wait_end("rerun", 3000);
        repeat (40) @(negedge clk);
        check("rerun_req_count", 32'(req_q.size()), 32'd3);
        check_words("rerun", exp_q);
        check("rerun_first_lat", 32'(qcyc(0, 0) - rel), 32'd12);
        check("rerun_init_done", 32'(init_done), 32'd1);
        check("rerun_init_err", 32'(init_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
